csr_exec_unit: RTL and testbench

- Multi-cycle execute stage for CSR instructions (CSRRW/S/C, CSRRWI/SI/CI), ECALL and MRET; sits directly upstream of the CSR register file.
- Takes decoded operations over a valid/ready handshake and sequences the register file's control vector (read, then read-modify-write).
- Returns the old CSR value for rd writeback, plus a PC redirect for ECALL/MRET, over a second valid/ready handshake.

---
 rtl/csr_exec_unit_pkg.sv | 38 +++
 rtl/csr_exec_unit_if.sv | 43 ++++
 rtl/csr_alu.sv | 42 ++++
 rtl/csr_exec_unit.sv | 139 +++++++++++++
 tb/tb_csr_exec_unit.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/csr_exec_unit_pkg.sv
// Shared definitions for the CSR execute stage: CSR addresses, funct3 codes,
// control-vector bit positions and the sequencing states.
package csr_exec_unit_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRS  = 3'b010;
  localparam logic [2:0] F3_CSRRC  = 3'b011;
  localparam logic [2:0] F3_CSRRWI = 3'b101;
  localparam logic [2:0] F3_CSRRSI = 3'b110;
  localparam logic [2:0] F3_CSRRCI = 3'b111;

  // Bit positions inside the {wr, rd, ecall, mret} control vector.
  localparam int CTL_WR    = 3;
  localparam int CTL_RD    = 2;
  localparam int CTL_ECALL = 1;
  localparam int CTL_MRET  = 0;

  localparam logic [63:0] ECALL_CAUSE_DEFAULT = 64'd11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_TRAP,
    ST_RESP
  } state_t;

  // funct3 values 000 and 100 carry no CSR operation.
  function automatic logic f3_legal(input logic [2:0] f3);
    return f3[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/csr_exec_unit_if.sv
// Op/result handshakes and CSR-file bus of the CSR execute stage.
// slave = the execute unit's view, master = the surrounding pipeline/CSR file.
interface csr_exec_unit_if #(
  parameter int XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      in_funct3;
  logic [11:0]     in_csr_addr;
  logic [4:0]      in_rs1_idx;
  logic [XLEN-1:0] in_rs1_data;
  logic [XLEN-1:0] in_pc;
  logic            in_ecall;
  logic            in_mret;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_rd_data;
  logic            out_redirect;
  logic [XLEN-1:0] out_redirect_pc;
  logic            out_illegal;

  logic [3:0]      csr_ctl;
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] mcause_value;
  logic [XLEN-1:0] write_csr_data;
  logic [XLEN-1:0] read_csr_data;

  modport slave (
    input  in_valid, in_funct3, in_csr_addr, in_rs1_idx, in_rs1_data, in_pc,
           in_ecall, in_mret, out_ready, read_csr_data,
    output in_ready, out_valid, out_rd_data, out_redirect, out_redirect_pc,
           out_illegal, csr_ctl, csr_addr, mcause_value, write_csr_data
  );

  modport master (
    output in_valid, in_funct3, in_csr_addr, in_rs1_idx, in_rs1_data, in_pc,
           in_ecall, in_mret, out_ready, read_csr_data,
    input  in_ready, out_valid, out_rd_data, out_redirect, out_redirect_pc,
           out_illegal, csr_ctl, csr_addr, mcause_value, write_csr_data
  );

endinterface

// File: rtl/csr_alu.sv
// Combinational CSR new-value compute: RW/RS/RC with register or zimm source,
// plus the write-enable rule (set/clear with rs1 field 0 never writes).
module csr_alu
  import csr_exec_unit_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [2:0]      funct3,
  input  logic [4:0]      rs1_idx,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] old,
  output logic [XLEN-1:0] wdata,
  output logic            wen
);

  logic [XLEN-1:0] src;

  always_comb begin
    src   = funct3[2] ? {{(XLEN-5){1'b0}}, rs1_idx} : rs1_data;
    wdata = old;
    wen   = 1'b0;
    case (funct3)
      F3_CSRRW, F3_CSRRWI: begin
        wdata = src;
        wen   = 1'b1;
      end
      F3_CSRRS, F3_CSRRSI: begin
        wdata = old | src;
        wen   = rs1_idx != 5'd0;
      end
      F3_CSRRC, F3_CSRRCI: begin
        wdata = old & ~src;
        wen   = rs1_idx != 5'd0;
      end
      default: begin
        wdata = old;
        wen   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/csr_exec_unit.sv
// Multi-cycle CSR/ECALL/MRET execute stage: sequences the CSR file through
// read then optional write (or one trap cycle) and returns the old value/redirect.
module csr_exec_unit
  import csr_exec_unit_pkg::*;
#(
  parameter int              XLEN        = 64,
  parameter logic [XLEN-1:0] ECALL_CAUSE = XLEN'(ECALL_CAUSE_DEFAULT)
) (
  input logic            clk,
  input logic            rst,
  csr_exec_unit_if.slave bus
);

  state_t          state_reg, state_next;
  logic [2:0]      funct3_reg;
  logic [11:0]     addr_reg;
  logic [4:0]      rs1_idx_reg;
  logic [XLEN-1:0] rs1_data_reg;
  logic [XLEN-1:0] pc_reg;
  logic            ecall_reg;
  logic            illegal_reg;
  logic            redirect_reg;
  logic [XLEN-1:0] rd_data_reg;
  logic [XLEN-1:0] redirect_pc_reg;

  logic [XLEN-1:0] alu_wdata;
  logic            alu_wen;
  logic            accept;
  logic            trap_op;
  logic [3:0]      ctl;
  logic [11:0]     addr_out;
  logic [XLEN-1:0] mcause_out;
  logic [XLEN-1:0] wdata_out;

  assign accept  = (state_reg == ST_IDLE) && bus.in_valid;
  assign trap_op = bus.in_ecall || bus.in_mret;

  csr_alu #(.XLEN(XLEN)) u_alu (
    .funct3   (funct3_reg),
    .rs1_idx  (rs1_idx_reg),
    .rs1_data (rs1_data_reg),
    .old      (rd_data_reg),
    .wdata    (alu_wdata),
    .wen      (alu_wen)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg       <= ST_IDLE;
      funct3_reg      <= '0;
      addr_reg        <= '0;
      rs1_idx_reg     <= '0;
      rs1_data_reg    <= '0;
      pc_reg          <= '0;
      ecall_reg       <= 1'b0;
      illegal_reg     <= 1'b0;
      redirect_reg    <= 1'b0;
      rd_data_reg     <= '0;
      redirect_pc_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        funct3_reg      <= bus.in_funct3;
        addr_reg        <= bus.in_csr_addr;
        rs1_idx_reg     <= bus.in_rs1_idx;
        rs1_data_reg    <= bus.in_rs1_data;
        pc_reg          <= bus.in_pc;
        ecall_reg       <= bus.in_ecall;
        illegal_reg     <= !trap_op && !f3_legal(bus.in_funct3);
        redirect_reg    <= trap_op;
        rd_data_reg     <= '0;
        redirect_pc_reg <= '0;
      end
      // The old value doubles as the ALU operand for the following WRITE cycle.
      if (state_reg == ST_READ) rd_data_reg <= bus.read_csr_data;
      if (state_reg == ST_TRAP) redirect_pc_reg <= bus.read_csr_data;
    end
  end

  always_comb begin
    state_next          = state_reg;
    bus.in_ready        = 1'b0;
    bus.out_valid       = 1'b0;
    bus.out_rd_data     = '0;
    bus.out_redirect    = 1'b0;
    bus.out_redirect_pc = '0;
    bus.out_illegal     = 1'b0;
    ctl                 = 4'b0000;
    addr_out            = '0;
    mcause_out          = '0;
    wdata_out           = '0;
    case (state_reg)
      ST_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          if (trap_op)                       state_next = ST_TRAP;
          else if (f3_legal(bus.in_funct3))  state_next = ST_READ;
          else                               state_next = ST_RESP;
        end
      end
      ST_READ: begin
        ctl[CTL_RD] = 1'b1;
        addr_out    = addr_reg;
        state_next  = alu_wen ? ST_WRITE : ST_RESP;
      end
      ST_WRITE: begin
        ctl[CTL_WR] = 1'b1;
        addr_out    = addr_reg;
        wdata_out   = alu_wdata;
        state_next  = ST_RESP;
      end
      ST_TRAP: begin
        if (ecall_reg) begin
          ctl[CTL_ECALL] = 1'b1;
          wdata_out      = pc_reg;
          mcause_out     = ECALL_CAUSE;
        end else begin
          ctl[CTL_MRET] = 1'b1;
        end
        state_next = ST_RESP;
      end
      ST_RESP: begin
        bus.out_valid       = 1'b1;
        bus.out_rd_data     = rd_data_reg;
        bus.out_redirect    = redirect_reg;
        bus.out_redirect_pc = redirect_pc_reg;
        bus.out_illegal     = illegal_reg;
        if (bus.out_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign bus.csr_ctl        = ctl;
  assign bus.csr_addr       = addr_out;
  assign bus.mcause_value   = mcause_out;
  assign bus.write_csr_data = wdata_out;

endmodule

// File: tb/tb_csr_exec_unit.sv
// Bench for csr_exec_unit: a behavioural CSR file plus an op-level reference
// model that predicts every CSR-bus cycle and each response; directed + random ops.
module tb_csr_exec_unit;
  import csr_exec_unit_pkg::*;

  typedef struct packed {
    logic [2:0]  funct3;
    logic [11:0] addr;
    logic [4:0]  idx;
    logic [63:0] data;
    logic [63:0] pc;
    logic        ecall;
    logic        mret;
  } op_t;

  typedef struct packed {
    logic [3:0]  ctl;
    logic [11:0] addr;
    logic [63:0] wdata;
    logic [63:0] mcause;
  } exp_t;

  typedef struct packed {
    logic [63:0] rd;
    logic        redirect;
    logic [63:0] rpc;
    logic        illegal;
  } resp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  csr_exec_unit_if #(.XLEN(64)) bus ();

  csr_exec_unit #(.XLEN(64), .ECALL_CAUSE(64'd11)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int    errors = 0;
  int    checks = 0;
  bit    chk_en = 1'b0;
  exp_t  exp_q[$];
  resp_t exp_resp;
  bit    resp_pending = 1'b0;
  exp_t  cur;

  bit [63:0] env_csr [4096];
  bit [63:0] ref_csr [4096];
  logic [63:0] last_wdata = '0;
  logic [63:0] rd_mux;
  logic [11:0] addr_list [5] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342};

  logic [63:0] last_rd, last_rpc;
  logic        last_redirect, last_illegal;
  int          last_lat;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h at t=%0t", name, act, req, $time);
    end
  endtask

  // Behavioural CSR file: combinational read, writes committed mid-cycle.
  always_comb begin
    rd_mux = 64'hBAD0_BAD0_BAD0_BAD0;
    if (bus.csr_ctl == 4'b0100)      rd_mux = env_csr[bus.csr_addr];
    else if (bus.csr_ctl == 4'b0010) rd_mux = env_csr[CSR_MTVEC];
    else if (bus.csr_ctl == 4'b0001) rd_mux = env_csr[CSR_MEPC];
  end
  assign bus.read_csr_data = rd_mux;

  always @(negedge clk) begin
    if (bus.csr_ctl == 4'b1000) begin
      env_csr[bus.csr_addr] = bus.write_csr_data;
      last_wdata = bus.write_csr_data;
    end else if (bus.csr_ctl == 4'b0010) begin
      env_csr[CSR_MEPC]   = bus.write_csr_data;
      env_csr[CSR_MCAUSE] = bus.mcause_value;
      last_wdata = bus.write_csr_data;
    end
  end

  // Compare process: every cycle is either a predicted CSR-bus cycle,
  // a pending response, or idle.
  always @(negedge clk) begin
    if (chk_en) begin
      if (exp_q.size() != 0) begin
        cur = exp_q.pop_front();
        chk("busy_ctl", 64'(bus.csr_ctl), 64'(cur.ctl));
        if (cur.ctl[3] || cur.ctl[2]) chk("busy_addr", 64'(bus.csr_addr), 64'(cur.addr));
        if (cur.ctl[3] || cur.ctl[1]) chk("busy_wdata", bus.write_csr_data, cur.wdata);
        chk("busy_mcause", bus.mcause_value, cur.mcause);
        chk("busy_out_valid", 64'(bus.out_valid), 64'd0);
        chk("busy_in_ready", 64'(bus.in_ready), 64'd0);
      end else if (resp_pending) begin
        chk("resp_valid", 64'(bus.out_valid), 64'd1);
        chk("resp_ctl", 64'(bus.csr_ctl), 64'd0);
        chk("resp_in_ready", 64'(bus.in_ready), 64'd0);
        chk("resp_rd", bus.out_rd_data, exp_resp.rd);
        chk("resp_redirect", 64'(bus.out_redirect), 64'(exp_resp.redirect));
        chk("resp_rpc", bus.out_redirect_pc, exp_resp.rpc);
        chk("resp_illegal", 64'(bus.out_illegal), 64'(exp_resp.illegal));
      end else begin
        chk("idle_in_ready", 64'(bus.in_ready), 64'd1);
        chk("idle_out_valid", 64'(bus.out_valid), 64'd0);
        chk("idle_ctl", 64'(bus.csr_ctl), 64'd0);
        chk("idle_mcause", bus.mcause_value, 64'd0);
      end
    end
  end

  // Reference model: what an accepted op must do to the CSR bus and return.
  task automatic model_accept(input op_t o);
    logic [63:0] old, src, nv;
    bit          w;
    exp_resp = '0;
    if (o.ecall) begin
      exp_q.push_back('{ctl: 4'b0010, addr: 12'h0, wdata: o.pc, mcause: 64'd11});
      exp_resp.redirect = 1'b1;
      exp_resp.rpc      = ref_csr[CSR_MTVEC];
      ref_csr[CSR_MEPC]   = o.pc;
      ref_csr[CSR_MCAUSE] = 64'd11;
    end else if (o.mret) begin
      exp_q.push_back('{ctl: 4'b0001, addr: 12'h0, wdata: 64'h0, mcause: 64'h0});
      exp_resp.redirect = 1'b1;
      exp_resp.rpc      = ref_csr[CSR_MEPC];
    end else if (o.funct3 == 3'b000 || o.funct3 == 3'b100) begin
      exp_resp.illegal = 1'b1;
    end else begin
      old = ref_csr[o.addr];
      src = o.funct3[2] ? 64'(o.idx) : o.data;
      exp_q.push_back('{ctl: 4'b0100, addr: o.addr, wdata: 64'h0, mcause: 64'h0});
      if (o.funct3[1:0] == 2'b01) begin
        nv = src; w = 1'b1;
      end else if (o.funct3[1:0] == 2'b10) begin
        nv = old | src; w = (o.idx != 0);
      end else begin
        nv = old & ~src; w = (o.idx != 0);
      end
      if (w) begin
        exp_q.push_back('{ctl: 4'b1000, addr: o.addr, wdata: nv, mcause: 64'h0});
        ref_csr[o.addr] = nv;
      end
      exp_resp.rd = old;
    end
    resp_pending = 1'b1;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic garbage_inputs();
    bus.in_funct3   = 3'($urandom);
    bus.in_csr_addr = 12'($urandom);
    bus.in_rs1_idx  = 5'($urandom);
    bus.in_rs1_data = {$urandom, $urandom};
    bus.in_pc       = {$urandom, $urandom};
    bus.in_ecall    = 1'($urandom);
    bus.in_mret     = 1'($urandom);
  endtask

  task automatic present(input op_t o);
    bus.in_valid    = 1'b1;
    bus.in_funct3   = o.funct3;
    bus.in_csr_addr = o.addr;
    bus.in_rs1_idx  = o.idx;
    bus.in_rs1_data = o.data;
    bus.in_pc       = o.pc;
    bus.in_ecall    = o.ecall;
    bus.in_mret     = o.mret;
  endtask

  task automatic issue(input op_t o, input int hold);
    int n;
    present(o);
    n = 0;
    while (!bus.in_ready && n < 20) begin step(); n++; end
    if (!bus.in_ready) begin
      chk("accept_timeout", 64'd0, 64'd1);
      bus.in_valid = 1'b0;
      return;
    end
    model_accept(o);
    step();
    garbage_inputs();
    bus.in_valid = 1'($urandom);
    n = 1;
    while (!bus.out_valid && n < 10) begin
      step(); garbage_inputs(); n++;
    end
    last_lat = n;
    if (!bus.out_valid) begin
      chk("resp_timeout", 64'd0, 64'd1);
      resp_pending = 1'b0;
      exp_q.delete();
      bus.in_valid = 1'b0;
      return;
    end
    repeat (hold) begin step(); garbage_inputs(); end
    bus.in_valid   = 1'b0;
    last_rd        = bus.out_rd_data;
    last_redirect  = bus.out_redirect;
    last_rpc       = bus.out_redirect_pc;
    last_illegal   = bus.out_illegal;
    bus.out_ready  = 1'b1;
    resp_pending   = 1'b0;
    step();
    bus.out_ready = 1'b0;
  endtask

  function automatic op_t mk(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] idx,
                             input logic [63:0] d, input logic [63:0] pc, input bit ec, input bit mr);
    op_t o;
    o.funct3 = f3; o.addr = a; o.idx = idx; o.data = d; o.pc = pc; o.ecall = ec; o.mret = mr;
    return o;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    int  r;
    o.funct3 = 3'($urandom);
    o.addr   = addr_list[$urandom_range(0, 4)];
    o.idx    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
    o.data   = {$urandom, $urandom};
    o.pc     = {$urandom, $urandom};
    r        = $urandom_range(0, 9);
    o.ecall  = (r == 0) || (r == 2);
    o.mret   = (r == 1) || (r == 2);
    return o;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish by t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_funct3 = '0; bus.in_csr_addr = '0; bus.in_rs1_idx = '0;
    bus.in_rs1_data = '0; bus.in_pc = '0; bus.in_ecall = 1'b0; bus.in_mret = 1'b0;
    repeat (3) step();
    chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
    chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset_ctl", 64'(bus.csr_ctl), 64'd0);
    chk("reset_out_rd", bus.out_rd_data, 64'd0);
    chk("reset_redirect", 64'(bus.out_redirect), 64'd0);
    chk("reset_illegal", 64'(bus.out_illegal), 64'd0);
    chk("reset_wdata", bus.write_csr_data, 64'd0);
    chk("reset_addr", 64'(bus.csr_addr), 64'd0);
    rst    = 1'b1;
    chk_en = 1'b1;
    step();

    issue(mk(F3_CSRRW, CSR_MTVEC, 5'd3, 64'h8000_0000, 64'h0, 0, 0), 0);
    chk("rw_rd", last_rd, 64'h0);
    chk("rw_lat", 64'(last_lat), 64'd3);
    chk("rw_wdata", last_wdata, 64'h8000_0000);
    issue(mk(F3_CSRRW, CSR_MTVEC, 5'd4, 64'h8000_0400, 64'h0, 0, 0), 1);
    chk("rw2_rd", last_rd, 64'h8000_0000);

    issue(mk(3'b000, 12'h0, 5'd0, 64'h0, 64'h8000_0100, 1, 0), 0);
    chk("ecall_redirect", 64'(last_redirect), 64'd1);
    chk("ecall_rpc", last_rpc, 64'h8000_0400);
    chk("ecall_wdata", last_wdata, 64'h8000_0100);
    chk("ecall_lat", 64'(last_lat), 64'd2);
    chk("ecall_rd", last_rd, 64'h0);

    issue(mk(F3_CSRRS, CSR_MCAUSE, 5'd0, 64'hFFFF, 64'h0, 0, 0), 0);
    chk("rs0_rd", last_rd, 64'd11);
    chk("rs0_lat", 64'(last_lat), 64'd2);

    issue(mk(F3_CSRRW, CSR_MSTATUS, 5'd1, 64'h1888, 64'h0, 0, 0), 0);
    issue(mk(F3_CSRRCI, CSR_MSTATUS, 5'd8, 64'hFFFF_FFFF, 64'h0, 0, 0), 0);
    chk("rci_rd", last_rd, 64'h1888);
    chk("rci_wdata", last_wdata, 64'h1880);
    chk("rci_lat", 64'(last_lat), 64'd3);

    issue(mk(F3_CSRRW, CSR_MEPC, 5'd2, 64'h8000_0104, 64'h0, 0, 0), 0);
    chk("mepc_rd", last_rd, 64'h8000_0100);
    issue(mk(3'b000, 12'h0, 5'd0, 64'h0, 64'h0, 0, 1), 3);
    chk("mret_rpc", last_rpc, 64'h8000_0104);
    chk("mret_redirect", 64'(last_redirect), 64'd1);
    chk("mret_lat", 64'(last_lat), 64'd2);

    issue(mk(3'b100, CSR_MSTATUS, 5'd5, 64'h1, 64'h0, 0, 0), 0);
    chk("ill_flag", 64'(last_illegal), 64'd1);
    chk("ill_lat", 64'(last_lat), 64'd1);
    chk("ill_rd", last_rd, 64'h0);

    // Reset taken while the unit is in its WRITE cycle.
    present(mk(F3_CSRRW, 12'h340, 5'd9, 64'h55, 64'h0, 0, 0));
    model_accept(mk(F3_CSRRW, 12'h340, 5'd9, 64'h55, 64'h0, 0, 0));
    step();
    bus.in_valid = 1'b0;
    step();
    rst = 1'b0;
    exp_q.delete();
    resp_pending = 1'b0;
    step();
    chk("rstw_ctl", 64'(bus.csr_ctl), 64'd0);
    chk("rstw_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rstw_in_ready", 64'(bus.in_ready), 64'd1);
    rst = 1'b1;
    step();

    for (int i = 0; i < 250; i++) begin
      bus.in_valid = 1'b0;
      garbage_inputs();
      repeat ($urandom_range(0, 2)) step();
      issue(rand_op(), $urandom_range(0, 3));
    end

    step();
    for (int i = 0; i < 5; i++)
      chk("final_csr", env_csr[addr_list[i]], ref_csr[addr_list[i]]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
